prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Downstream consumer of the sequential two's-complement multiplier; accumulates NTERMS consecutive signed products into one sum (dot-product / MAC tail).
- Re-launches the multiplier for each term by pulsing the multiplier's reset input. Captures each product when the multiplier's ready level rises.
- Presents the final sum on a valid/ready output handshake.

Parameters:
WIDTH, 8, multiplier operand width; product input is 2*WIDTH bits signed
NTERMS, 4, products accumulated per result (>=1)
GUARD, 2, extra accumulator bits; ACCW = 2*WIDTH+GUARD
CTRW, 3, term counter width; must satisfy 2**CTRW >= NTERMS

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
start  in  1  level; begins a new accumulation when idle
p_in  in  2*WIDTH  signed product from multiplier
p_rdy  in  1  multiplier ready level (stays high once done)
mult_rst  out  1  one-cycle pulse, drives multiplier reset to launch a term
acc_out  out  ACCW  signed accumulated sum, valid when out_valid
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
ovf  out  1  sticky: saturation occurred in current result
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous): state=IDLE; acc_out=0, out_valid=0, ovf=0, mult_rst=0, busy=0, term count=0, arm flag=0. Reset mid-operation abandons the partial sum; no output produced.
- States: IDLE, LAUNCH, WAIT, ACC, DONE.
- IDLE: if start=1 -> LAUNCH; clear acc_out, ovf, count.
- LAUNCH (1 cycle): mult_rst=1 registered for exactly this cycle; arm flag cleared; -> WAIT.
- WAIT: arm flag set in any cycle p_rdy=0. Capture only when arm=1 and p_rdy=1 (rising edge after launch); a p_rdy held high across the launch is never captured. On capture register p_in -> ACC.
- ACC (1 cycle): sum = acc_out + sign-extend(captured p to ACCW). If signed overflow, saturate to +2^(ACCW-1)-1 or -2^(ACCW-1) by operand sign and set ovf. count+1; if count==NTERMS-1 -> DONE else -> LAUNCH.
- DONE: out_valid=1, acc_out and ovf held stable. On out_valid&&out_ready: out_valid drops next cycle; if start=1 that cycle -> LAUNCH with acc_out/ovf/count cleared, else -> IDLE (acc_out retained until next start).
- Latency per term: LAUNCH + multiplier time + WAIT capture + ACC = multiplier cycles + 3.
- start ignored outside IDLE and the DONE handoff cycle. out_ready ignored outside DONE.
- No multiplier timeout; WAIT persists until qualified p_rdy.

Test Plan:
- Defaults, four products of 6 (0x0006) -> exactly four mult_rst pulses, out_valid with acc_out=24, ovf=0.
- Signed mix -12 (0xFFF4), 20, -3, 1 -> acc_out=6 (ACCW=18, 0x00006), ovf=0.
- GUARD=0, NTERMS=2, products 16384, 16384 -> acc_out=32767 (0x7FFF), ovf=1; next run with 1,1 -> acc_out=2, ovf=0.
- out_ready low 5 cycles in DONE -> acc_out/out_valid stable, no mult_rst; out_ready=1 with start=1 -> LAUNCH next cycle, accumulator cleared.
- p_rdy held high from IDLE through LAUNCH -> no capture until p_rdy seen 0 then 1; each term counted once.
- reset asserted in WAIT after 2 terms -> next cycle all outputs at reset values; new start gives a correct fresh 4-term sum.

Source files
------------

// File: rtl/prod_accum.sv
// ---------------------------------------------------------------------------
// prod_accum
//   Accumulates NTERMS consecutive signed products from a sequential
//   two's-complement multiplier into one saturating sum. Each term is
//   launched by pulsing the multiplier's reset. The product is captured on
//   the first rising edge of the multiplier's ready level after that launch.
//   The finished sum is offered on a valid/ready handshake.
//
// Parameters
//   WIDTH   multiplier operand width (product is 2*WIDTH bits, signed)
//   NTERMS  products per result (>= 1)
//   GUARD   extra accumulator bits, ACCW = 2*WIDTH + GUARD
//   CTRW    term counter width, 2**CTRW >= NTERMS
//
// Ports
//   i_clk        clock, all state on rising edge
//   i_reset      synchronous active-high reset
//   i_start      level, begins an accumulation when idle / at result handoff
//   i_p_in       signed product from the multiplier
//   i_p_rdy      multiplier ready level (stays high once done)
//   o_mult_rst   one-cycle pulse that launches the multiplier
//   o_acc_out    signed accumulated sum
//   o_out_valid  result available
//   i_out_ready  consumer accepts the result
//   o_ovf        sticky saturation flag for the current result
//   o_busy       high in every state except IDLE
// ---------------------------------------------------------------------------
module prod_accum #(
  parameter int WIDTH  = 8,
  parameter int NTERMS = 4,
  parameter int GUARD  = 2,
  parameter int CTRW   = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [2*WIDTH-1:0]         i_p_in,
  input  logic                       i_p_rdy,
  output logic                       o_mult_rst,
  output logic [2*WIDTH+GUARD-1:0]   o_acc_out,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic                       o_ovf,
  output logic                       o_busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int ACCW = PW + GUARD;
  localparam logic [CTRW-1:0] LAST_TERM = CTRW'(NTERMS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_ACC    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Signed add that clamps to the representable range; the MSB of the
  // returned vector flags that clamping happened. Overflow is only possible
  // when both operands share a sign, so the clamp direction follows that sign.
  function automatic logic [ACCW:0] sat_add(
    input logic signed [ACCW-1:0] a,
    input logic signed [ACCW-1:0] b
  );
    logic signed [ACCW-1:0] raw;
    logic                   ov;
    raw = a + b;
    ov  = (a[ACCW-1] == b[ACCW-1]) && (raw[ACCW-1] != a[ACCW-1]);
    if (ov) begin
      if (a[ACCW-1]) begin
        raw = {1'b1, {(ACCW-1){1'b0}}};
      end else begin
        raw = {1'b0, {(ACCW-1){1'b1}}};
      end
    end
    return {ov, raw};
  endfunction

  state_t                  r_state;
  logic signed [ACCW-1:0]  r_acc;
  logic signed [PW-1:0]    r_prod;
  logic [CTRW-1:0]         r_cnt;
  logic                    r_arm;
  logic                    r_ovf;
  logic                    r_mult_rst;
  logic                    r_out_valid;
  logic                    r_busy;

  logic signed [ACCW-1:0]  w_prod_ext;
  logic [ACCW:0]           w_sat;

  // Sign-extend the captured product to accumulator width (a plain cast
  // also covers GUARD = 0, where no extension bits exist).
  assign w_prod_ext = ACCW'(r_prod);
  assign w_sat      = sat_add(r_acc, w_prod_ext);

  // Control FSM with all outputs registered; each output changes on the
  // same edge as the state transition that defines it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
      r_arm       <= 1'b0;
      r_ovf       <= 1'b0;
      r_mult_rst  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_LAUNCH;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_mult_rst <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_LAUNCH: begin
          // The multiplier reset is high for exactly this one cycle.
          r_mult_rst <= 1'b0;
          r_arm      <= 1'b0;
          r_state    <= S_WAIT;
        end

        S_WAIT: begin
          // Ready may still be high from the previous product; only a
          // low-then-high sequence after the launch marks a fresh result.
          if (!i_p_rdy) begin
            r_arm <= 1'b1;
          end
          if (r_arm && i_p_rdy) begin
            r_prod  <= i_p_in;
            r_state <= S_ACC;
          end
        end

        S_ACC: begin
          r_acc <= w_sat[ACCW-1:0];
          if (w_sat[ACCW]) begin
            r_ovf <= 1'b1;
          end
          r_cnt <= r_cnt + CTRW'(1);
          if (r_cnt == LAST_TERM) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_state    <= S_LAUNCH;
            r_mult_rst <= 1'b1;
          end
        end

        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (i_start) begin
              // Back-to-back result: skip IDLE and relaunch immediately.
              r_state    <= S_LAUNCH;
              r_acc      <= '0;
              r_ovf      <= 1'b0;
              r_cnt      <= '0;
              r_mult_rst <= 1'b1;
            end else begin
              // Sum stays visible on o_acc_out until the next start.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_mult_rst  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_arm       <= 1'b0;
        end
      endcase
    end
  end

  assign o_mult_rst  = r_mult_rst;
  assign o_acc_out   = r_acc;
  assign o_out_valid = r_out_valid;
  assign o_ovf       = r_ovf;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_prod_accum.sv
// ---------------------------------------------------------------------------
// tb_prod_accum
//   Drives two prod_accum instances (default parameters, and GUARD=0 /
//   NTERMS=2 for saturation) from a behavioural multiplier responder and
//   compares every result with a saturating-sum reference model.
// ---------------------------------------------------------------------------
module tb_prod_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               start_s     [2];
  logic               out_ready_s [2];
  logic               p_rdy_s     [2];
  logic [15:0]        p_in_s      [2];

  logic               mr0, mr1, vl0, vl1, ov0, ov1, by0, by1;
  logic signed [17:0] acc0;
  logic signed [15:0] acc1;

  prod_accum #(.WIDTH(8), .NTERMS(4), .GUARD(2), .CTRW(3)) u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_start(start_s[0]), .i_p_in(p_in_s[0]),
    .i_p_rdy(p_rdy_s[0]), .o_mult_rst(mr0), .o_acc_out(acc0),
    .o_out_valid(vl0), .i_out_ready(out_ready_s[0]), .o_ovf(ov0), .o_busy(by0)
  );

  prod_accum #(.WIDTH(8), .NTERMS(2), .GUARD(0), .CTRW(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start_s[1]), .i_p_in(p_in_s[1]),
    .i_p_rdy(p_rdy_s[1]), .o_mult_rst(mr1), .o_acc_out(acc1),
    .o_out_valid(vl1), .i_out_ready(out_ready_s[1]), .o_ovf(ov1), .o_busy(by1)
  );

  int checks = 0;
  int errors = 0;

  int nterms [2] = '{4, 2};
  int accw   [2] = '{18, 16};

  // Multiplier responder state and the products it will hand out.
  logic signed [15:0] prod_tab [2][16];
  int  prod_rd   [2];
  int  rst_cnt   [2];
  bit  pend      [2];
  int  hold_cfg  [2];
  int  hold_left [2];
  int  lat_max   [2];
  int  lat_left  [2];

  function automatic int g_acc(input int k);
    return (k != 0) ? int'(acc1) : int'(acc0);
  endfunction
  function automatic int g_mr(input int k);
    return (k != 0) ? int'(mr1) : int'(mr0);
  endfunction
  function automatic int g_vl(input int k);
    return (k != 0) ? int'(vl1) : int'(vl0);
  endfunction
  function automatic int g_ov(input int k);
    return (k != 0) ? int'(ov1) : int'(ov0);
  endfunction
  function automatic int g_by(input int k);
    return (k != 0) ? int'(by1) : int'(by0);
  endfunction

  // Multiplier model: after a reset pulse it optionally keeps ready high for
  // a few cycles (stale result still showing), drops ready, waits a random
  // latency, then raises ready with the next product from the table.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        pend[k]    = 1'b0;
        p_rdy_s[k] = 1'b1;
      end else if (g_mr(k) != 0) begin
        rst_cnt[k]++;
        pend[k]      = 1'b1;
        hold_left[k] = hold_cfg[k];
        lat_left[k]  = $urandom_range(lat_max[k], 0);
        p_in_s[k]    = 16'($urandom);
      end else if (pend[k]) begin
        if (hold_left[k] > 0) begin
          hold_left[k]--;
          p_in_s[k] = 16'($urandom);
        end else if (p_rdy_s[k]) begin
          p_rdy_s[k] = 1'b0;
          p_in_s[k]  = 16'($urandom);
        end else if (lat_left[k] > 0) begin
          lat_left[k]--;
        end else begin
          p_rdy_s[k] = 1'b1;
          p_in_s[k]  = prod_tab[k][prod_rd[k]];
          prod_rd[k]++;
          pend[k]    = 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: running sum clamped to ACCW-bit signed range after each term.
  task automatic expect_sum(input int k, input int n, output int s, output int o);
    longint mx, mn, t;
    mx = (64'sd1 <<< (accw[k] - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    s  = 0;
    o  = 0;
    for (int i = 0; i < n; i++) begin
      t = longint'(s) + longint'(prod_tab[k][i]);
      if (t > mx) begin
        t = mx;
        o = 1;
      end else if (t < mn) begin
        t = mn;
        o = 1;
      end
      s = int'(t);
    end
  endtask

  task automatic load_random(input int k);
    for (int i = 0; i < nterms[k]; i++) prod_tab[k][i] = 16'($urandom);
  endtask

  // One full result. chain_in: DUT is already in LAUNCH from a previous
  // handoff. chain_out: hand off with start high to relaunch immediately.
  task automatic run_txn(input int k, input int dly, input int hold,
                         input bit chain_in, input bit chain_out);
    int exp_s, exp_o, base, cyc;
    expect_sum(k, nterms[k], exp_s, exp_o);
    hold_cfg[k] = hold;
    prod_rd[k]  = 0;
    if (!chain_in) begin
      start_s[k] = 1'b1;
      tick();
      start_s[k] = 1'b0;
    end
    check_eq("launch_pulse", g_mr(k), 1);
    check_eq("launch_clear", g_acc(k), 0);
    check_eq("launch_busy", g_by(k), 1);
    base = rst_cnt[k];
    cyc  = 0;
    while (g_vl(k) == 0 && cyc < 400) begin
      start_s[k] = 1'($urandom_range(1, 0));
      tick();
      cyc++;
    end
    check_eq("done_in_time", int'(cyc < 400), 1);
    check_eq("sum", g_acc(k), exp_s);
    check_eq("ovf", g_ov(k), exp_o);
    check_eq("launch_count", rst_cnt[k] - base, nterms[k]);
    for (int d = 0; d < dly; d++) begin
      start_s[k] = 1'($urandom_range(1, 0));
      tick();
      check_eq("stall_sum", g_acc(k), exp_s);
      check_eq("stall_valid", g_vl(k), 1);
      check_eq("stall_no_launch", g_mr(k), 0);
    end
    out_ready_s[k] = 1'b1;
    start_s[k]     = chain_out;
    tick();
    out_ready_s[k] = 1'b0;
    start_s[k]     = 1'b0;
    check_eq("valid_drop", g_vl(k), 0);
    if (chain_out) begin
      check_eq("chain_launch", g_mr(k), 1);
      check_eq("chain_clear", g_acc(k), 0);
      check_eq("chain_ovf_clear", g_ov(k), 0);
    end else begin
      check_eq("idle_busy", g_by(k), 0);
      check_eq("idle_retain", g_acc(k), exp_s);
    end
  endtask

  task automatic check_reset_state(input int k);
    check_eq("rst_mult_rst", g_mr(k), 0);
    check_eq("rst_valid", g_vl(k), 0);
    check_eq("rst_busy", g_by(k), 0);
    check_eq("rst_acc", g_acc(k), 0);
    check_eq("rst_ovf", g_ov(k), 0);
  endtask

  initial begin
    int base, cyc;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; out_ready_s[k] = 1'b0; p_rdy_s[k] = 1'b1;
      p_in_s[k] = 16'h0000; prod_rd[k] = 0; rst_cnt[k] = 0; pend[k] = 1'b0;
      hold_cfg[k] = 0; hold_left[k] = 0; lat_max[k] = 3; lat_left[k] = 0;
    end
    repeat (3) tick();
    reset = 1'b0;
    check_reset_state(0);
    check_reset_state(1);

    // Four products of 6.
    for (int i = 0; i < 4; i++) prod_tab[0][i] = 16'sd6;
    run_txn(0, 0, 0, 1'b0, 1'b0);

    // Signed mix -12, 20, -3, 1 with a 5-cycle consumer stall.
    prod_tab[0][0] = -16'sd12; prod_tab[0][1] = 16'sd20;
    prod_tab[0][2] = -16'sd3;  prod_tab[0][3] = 16'sd1;
    run_txn(0, 5, 0, 1'b0, 1'b0);

    // Stale ready held high well into WAIT.
    load_random(0);
    run_txn(0, 1, 3, 1'b0, 1'b0);

    // Back-to-back results through the DONE handoff.
    load_random(0);
    run_txn(0, 2, 1, 1'b0, 1'b1);
    load_random(0);
    run_txn(0, 0, 0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 20; t++) begin
      load_random(0);
      lat_max[0] = $urandom_range(5, 0);
      run_txn(0, $urandom_range(3, 0), $urandom_range(2, 0), 1'b0, 1'b0);
    end

    // Reset while waiting on the third term, then a fresh sum.
    load_random(0);
    hold_cfg[0] = 0;
    prod_rd[0]  = 0;
    start_s[0]  = 1'b1;
    tick();
    start_s[0]  = 1'b0;
    base = rst_cnt[0];
    cyc  = 0;
    while (rst_cnt[0] - base < 3 && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("third_launch_seen", int'(cyc < 200), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state(0);
    load_random(0);
    run_txn(0, 1, 0, 1'b0, 1'b0);

    // Saturation on the narrow instance, then a clean follow-up.
    prod_tab[1][0] = 16'sd16384; prod_tab[1][1] = 16'sd16384;
    run_txn(1, 0, 0, 1'b0, 1'b0);
    prod_tab[1][0] = 16'sd1; prod_tab[1][1] = 16'sd1;
    run_txn(1, 0, 0, 1'b0, 1'b0);
    prod_tab[1][0] = -16'sd32768; prod_tab[1][1] = -16'sd5;
    run_txn(1, 1, 1, 1'b0, 1'b0);
    for (int t = 0; t < 15; t++) begin
      load_random(1);
      lat_max[1] = $urandom_range(4, 0);
      run_txn(1, $urandom_range(2, 0), $urandom_range(2, 0), 1'b0,
              1'($urandom_range(1, 0)) && (t != 14));
      // A chained handoff leaves the DUT in LAUNCH; finish that run too.
      if (g_mr(1) != 0) begin
        load_random(1);
        run_txn(1, 0, 0, 1'b1, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
